// File: rtl/mlu_serial_if.sv
// mlu_serial_if: bundles the control-unit request/response signals and the
// nibble-wide link to the combinational mlu_slice into one interface.
// The "slave" side is the sequencer. The "master" side is its environment:
// the control unit together with the slice, which drives SLICE_OUT back.
interface mlu_serial_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] OUT;
    logic             ZERO;
    logic             CARRY;
    logic             OVERFLOW;
    logic [3:0]       SLICE_A;
    logic [3:0]       SLICE_B;
    logic [2:0]       SLICE_OP;
    logic             SLICE_C_IN;
    logic [7:0]       SLICE_OUT;

    modport master (
        output START, OP, A, B, SLICE_OUT,
        input  BUSY, DONE, OUT, ZERO, CARRY, OVERFLOW,
        input  SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN
    );

    modport slave (
        input  START, OP, A, B, SLICE_OUT,
        output BUSY, DONE, OUT, ZERO, CARRY, OVERFLOW,
        output SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN
    );
endinterface

// File: rtl/mlu_serial.sv
// mlu_serial: nibble-serial sequencer for a single combinational mlu_slice.
// Latches a WIDTH-bit operation, feeds one nibble per cycle (LSB first),
// ripples the carry between cycles and assembles the result plus flags.
// WIDTH must be a multiple of 4 and at least 8.
// Optional build macro: MLU_SERIAL_OVERFLOW_EN adds a registered signed
// overflow flag; without it OVERFLOW is tied low and no logic is built.
// Opcode map shared with the slice:
//   0 NOP0, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 NOP1.
module mlu_serial #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        N_RST,
    mlu_serial_if.slave bus
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    localparam logic [2:0] MLU_ADD = 3'd1;
    localparam logic [2:0] MLU_SUB = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_op;
    logic             r_carry;
    logic             r_zeroAcc;
    logic             r_zero;
    logic             r_carryFlag;

    logic             w_accept;
    logic             w_lastNib;
    logic             w_run;
    logic [3:0]       w_res;
    logic             w_carryNext;
    logic             w_zeroNext;
    logic             w_arith;
    logic             w_unusedSliceBit;

    // Decode the slice response for the nibble currently in flight.
    assign w_res            = bus.SLICE_OUT[3:0];
    assign w_carryNext      = bus.SLICE_OUT[5] | (bus.SLICE_OUT[4] & r_carry);
    assign w_zeroNext       = r_zeroAcc & bus.SLICE_OUT[6];
    assign w_unusedSliceBit = bus.SLICE_OUT[7];
    assign w_arith          = (r_op == MLU_ADD) || (r_op == MLU_SUB);
    assign w_run            = (r_state == S_RUN);

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the accept and last-nibble strobes.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_lastNib   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_accept    = 1'b1;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_lastNib   = 1'b1;
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Operand latch, carry ripple, result assembly and end-of-op flags.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_zeroAcc   <= 1'b0;
            r_zero      <= 1'b0;
            r_carryFlag <= 1'b0;
        end else if (w_accept) begin
            r_idx       <= '0;
            r_a         <= bus.A;
            r_b         <= bus.B;
            r_op        <= bus.OP;
            r_carry     <= (bus.OP == MLU_SUB);
            r_zeroAcc   <= 1'b1;
            r_zero      <= 1'b0;
            r_carryFlag <= 1'b0;
        end else if (w_run) begin
            r_out[{r_idx, 2'b00} +: 4] <= w_res;
            r_carry   <= w_carryNext;
            r_zeroAcc <= w_zeroNext;
            if (w_lastNib) begin
                r_idx       <= '0;
                r_zero      <= w_zeroNext;
                r_carryFlag <= w_arith ? w_carryNext : 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef MLU_SERIAL_OVERFLOW_EN
    logic r_ovf;
    logic w_ovfNext;

    // Signed overflow from the operand sign bits and the top result nibble.
    always_comb begin
        w_ovfNext = 1'b0;
        if (r_op == MLU_ADD) begin
            w_ovfNext = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[3] != r_a[WIDTH-1]);
        end else if (r_op == MLU_SUB) begin
            w_ovfNext = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[3] != r_a[WIDTH-1]);
        end
    end

    // Overflow is cleared on accept and captured with the final nibble.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_lastNib) begin
            r_ovf <= w_ovfNext;
        end
    end

    assign bus.OVERFLOW = r_ovf;
`else
    assign bus.OVERFLOW = 1'b0;
`endif

    // Status outputs come straight from registers.
    assign bus.BUSY  = (r_state != S_IDLE);
    assign bus.DONE  = (r_state == S_DONE);
    assign bus.OUT   = r_out;
    assign bus.ZERO  = r_zero;
    assign bus.CARRY = r_carryFlag;

    // Slice inputs are selected from registered state only and held at 0 outside RUN.
    assign bus.SLICE_A    = w_run ? r_a[{r_idx, 2'b00} +: 4] : 4'd0;
    assign bus.SLICE_B    = w_run ? r_b[{r_idx, 2'b00} +: 4] : 4'd0;
    assign bus.SLICE_OP   = w_run ? r_op : 3'd0;
    assign bus.SLICE_C_IN = w_run ? r_carry : 1'b0;

endmodule
